// File: rtl/memoria_bcd_pkg.sv
// Shared types, seven-segment constants and helpers for the memoria_bcd display path.
// Segment vectors are active-low, ordered gfedcba.
package memoria_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9 after the shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n, input logic blank);
    logic [6:0] s;
    case (n)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return blank ? SEG_BLANK : s;
  endfunction

  // True when `digits` decimal digits can show every value of a `width`-bit word.
  function automatic bit digits_ok(input int width, input int digits);
    longint p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p > ((longint'(1) << width) - 1);
  endfunction

endpackage

// File: rtl/conversor_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per cycle MSB first.
// Start is accepted only in IDLE; bcd holds the result while done is high.
module conversor_bcd
  import memoria_bcd_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int N_DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  state_t                state;
  state_t                state_nxt;
  logic [IN_W-1:0]       bin_sr;
  logic [4*N_DIGITS-1:0] bcd_acc;
  logic [4*N_DIGITS-1:0] adj;
  logic [CNT_W-1:0]      step;
  logic                  last_step;

  assign last_step = (step == CNT_W'(IN_W - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_comb begin
    adj = bcd_acc;
    for (int d = 0; d < N_DIGITS; d++) adj[4*d +: 4] = add3(bcd_acc[4*d +: 4]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bin_sr  <= '0;
      bcd_acc <= '0;
      step    <= '0;
    end else if (state == IDLE && start) begin
      bin_sr  <= bin;
      bcd_acc <= '0;
      step    <= '0;
    end else if (state == CONV) begin
      {bcd_acc, bin_sr} <= {adj[4*N_DIGITS-2:0], bin_sr, 1'b0};
      step              <= step + 1'b1;
    end
  end

  assign bcd = bcd_acc;

endmodule

// File: rtl/memoria_bcd.sv
// Single-port RAM with registered read and a seven-segment readout of the current word and address.
// A new conversion is launched whenever the registered word or address differs from the last one shown.
module memoria_bcd
  import memoria_bcd_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int DIGITS      = 3,
  parameter int ADDR_DIGITS = 2,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W-1:0]        data,
  input  logic                     wren,
  output logic [DATA_W-1:0]        out,
  output logic [7*DIGITS-1:0]      hex_data,
  output logic [7*ADDR_DIGITS-1:0] hex_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     led_wren
);

  if (DATA_W < 2 || DATA_W > 16) begin : g_bad_data_w
    $error("memoria_bcd: DATA_W must lie in 2..16");
  end
  if (ADDR_W > DATA_W) begin : g_bad_addr_w
    $error("memoria_bcd: ADDR_W must not exceed DATA_W");
  end
  if (!digits_ok(DATA_W, DIGITS)) begin : g_bad_digits
    $error("memoria_bcd: DIGITS too small for DATA_W");
  end
  if (!digits_ok(ADDR_W, ADDR_DIGITS)) begin : g_bad_addr_digits
    $error("memoria_bcd: ADDR_DIGITS too small for ADDR_W");
  end

  logic [DATA_W-1:0]        mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0]        addr_q;
  logic [DATA_W-1:0]        last_val;
  logic [ADDR_W-1:0]        last_addr;
  logic                     start;
  logic                     busy_d, busy_a, done_d, done_a, commit;
  logic [4*DIGITS-1:0]      bcd_d, dig_data;
  logic [4*ADDR_DIGITS-1:0] bcd_a, dig_addr;
  logic                     done_q;
  logic [DIGITS-1:0]        blank_d;
  logic [ADDR_DIGITS-1:0]   blank_a;

  // NOTE: RAM arrays get no reset branch; contents survive reset and map onto plain memory.
  always_ff @(posedge clock) begin
    if (wren) mem[address] <= data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out      <= '0;
      addr_q   <= '0;
      led_wren <= 1'b0;
    end else begin
      out      <= wren ? data : mem[address];
      addr_q   <= address;
      led_wren <= wren;
    end
  end

  assign busy   = busy_d | busy_a;
  assign commit = done_d & done_a;
  assign start  = !busy && ((out != last_val) || (addr_q != last_addr));

  always_ff @(posedge clock) begin
    if (reset) begin
      last_val  <= '0;
      last_addr <= '0;
    end else if (start) begin
      last_val  <= out;
      last_addr <= addr_q;
    end
  end

  conversor_bcd #(.IN_W(DATA_W), .N_DIGITS(DIGITS)) u_conv_data (
    .clock (clock),
    .reset (reset),
    .start (start),
    .bin   (last_val_src()),
    .busy  (busy_d),
    .done  (done_d),
    .bcd   (bcd_d)
  );

  // Address is zero-extended so both engines finish on the same cycle.
  conversor_bcd #(.IN_W(DATA_W), .N_DIGITS(ADDR_DIGITS)) u_conv_addr (
    .clock (clock),
    .reset (reset),
    .start (start),
    .bin   (DATA_W'(addr_q)),
    .busy  (busy_a),
    .done  (done_a),
    .bcd   (bcd_a)
  );

  function automatic logic [DATA_W-1:0] last_val_src();
    return out;
  endfunction

  // Digit registers change only at the end of a conversion, so partial results never reach the pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      dig_data <= '0;
      dig_addr <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) begin
        dig_data <= bcd_d;
        dig_addr <= bcd_a;
      end
    end
  end

  assign done = done_q;

  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank_d    = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (dig_data[4*i +: 4] == 4'd0);
      blank_d[i] = BLANK_LZ && zero_above;
    end
  end

  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank_a    = '0;
    for (int i = ADDR_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (dig_addr[4*i +: 4] == 4'd0);
      blank_a[i] = BLANK_LZ && zero_above;
    end
  end

  always_comb begin
    hex_data = '1;
    for (int i = 0; i < DIGITS; i++) hex_data[7*i +: 7] = seg7(dig_data[4*i +: 4], blank_d[i]);
  end

  always_comb begin
    hex_addr = '1;
    for (int i = 0; i < ADDR_DIGITS; i++) hex_addr[7*i +: 7] = seg7(dig_addr[4*i +: 4], blank_a[i]);
  end

endmodule

// File: tb/tb_memoria_bcd.sv
// Self-checking bench for memoria_bcd: scoreboard of registered (word, address) snapshots,
// monitor checks every done pulse against the snapshot taken DATA_W+2 edges earlier.
module tb_memoria_bcd;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int LAT = DW + 2;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef struct {
    int cyc;
    int val;
    int addr;
  } snap_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data = '0;
  logic          wren = 1'b0;
  logic [DW-1:0] out;
  logic [20:0]   hex_data;
  logic [13:0]   hex_addr;
  logic          busy, done, led_wren;

  logic [AW-1:0] w_address = '0;
  logic [9:0]    w_data = '0;
  logic          w_wren = 1'b0;
  logic [9:0]    w_out;
  logic [27:0]   w_hex_data;
  logic [13:0]   w_hex_addr;
  logic          w_busy, w_done, w_led_wren;

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    mem_m [32];
  int    exp_out = 0;
  int    exp_addr = 0;
  int    exp_led = 0;
  snap_t sb_q [$];

  memoria_bcd dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .data     (data),
    .wren     (wren),
    .out      (out),
    .hex_data (hex_data),
    .hex_addr (hex_addr),
    .busy     (busy),
    .done     (done),
    .led_wren (led_wren)
  );

  memoria_bcd #(.DATA_W(10), .ADDR_W(5), .DIGITS(4), .ADDR_DIGITS(2), .BLANK_LZ(1'b0)) dut_w (
    .clock    (clock),
    .reset    (reset),
    .address  (w_address),
    .data     (w_data),
    .wren     (w_wren),
    .out      (w_out),
    .hex_data (w_hex_data),
    .hex_addr (w_hex_addr),
    .busy     (w_busy),
    .done     (w_done),
    .led_wren (w_led_wren)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal digits with optional leading-zero blanking, straight from the display rules.
  function automatic logic [63:0] hex_of(input int v, input int ndig, input bit blz);
    logic [63:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < ndig; i++) begin
      if (blz && i > 0 && v < p) r[7*i +: 7] = 7'h7f;
      else                       r[7*i +: 7] = SEG_TAB[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic tick();
    snap_t s;
    @(posedge clock);
    cyc++;
    if (wren) mem_m[address] = int'(data);
    if (reset) begin
      exp_out  = 0;
      exp_addr = 0;
      exp_led  = 0;
    end else begin
      exp_out  = mem_m[address];
      exp_addr = int'(address);
      exp_led  = int'(wren);
      s.cyc  = cyc;
      s.val  = exp_out;
      s.addr = exp_addr;
      sb_q.push_back(s);
      if (sb_q.size() > 64) void'(sb_q.pop_front());
    end
    #1;
    check("out", out, exp_out);
    check("led_wren", led_wren, exp_led);
  endtask

  task automatic settle();
    wren = 1'b0;
    repeat (40) tick();
    check("settle_busy", busy, 0);
    check("settle_hex_data", hex_data, hex_of(exp_out, 3, 1'b1));
    check("settle_hex_addr", hex_addr, hex_of(exp_addr, 2, 1'b1));
  endtask

  // Monitor: every done must show the snapshot registered LAT edges before it.
  initial begin : monitor
    logic [20:0] prev_hd;
    logic [13:0] prev_ha;
    int target;
    prev_hd = '1;
    prev_ha = '1;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_hd = hex_data;
        prev_ha = hex_addr;
        continue;
      end
      if (done) begin
        done_cnt++;
        target = cyc - LAT;
        while (sb_q.size() > 0 && sb_q[0].cyc < target) void'(sb_q.pop_front());
        if (sb_q.size() == 0) begin
          check("done_snapshot_cycle", -1, target);
        end else begin
          check("done_snapshot_cycle", sb_q[0].cyc, target);
          check("done_hex_data", hex_data, hex_of(sb_q[0].val, 3, 1'b1));
          check("done_hex_addr", hex_addr, hex_of(sb_q[0].addr, 2, 1'b1));
        end
      end else begin
        check("hex_stable", {hex_data, hex_addr}, {prev_hd, prev_ha});
      end
      prev_hd = hex_data;
      prev_ha = hex_addr;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int d0, edges, hold;
    foreach (mem_m[i]) mem_m[i] = 0;

    // Reset, then hold address 0 writing 0: nothing differs from 0, so no conversion.
    wren = 1'b1; address = '0; data = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hex_data", hex_data, 21'b1111111_1111111_1000000);
    check("rst_hex_addr", hex_addr, 14'b1111111_1000000);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (20) tick();
    check("no_done_after_reset", done_cnt, d0);
    check("idle_hex_data", hex_data, 21'b1111111_1111111_1000000);

    // Fill the RAM with random words below 255.
    for (int a = 0; a < 32; a++) begin
      wren = 1'b1; address = AW'(a); data = DW'($urandom_range(0, 254));
      tick();
    end
    settle();

    // Write 255 at 31: display follows 10 edges after the write edge.
    wren = 1'b1; address = 5'd31; data = 8'd255;
    tick();
    check("write_through", out, 255);
    wren = 1'b0;
    edges = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (done) begin edges = n; break; end
    end
    check("latency_edges", edges, 10);
    check("hex_255", hex_data, 21'b0100100_0010010_0010010);
    check("hex_addr_31", hex_addr, 14'b0110000_1111001);
    settle();

    // Write 7 at 4, read it back: leading zeros blank.
    wren = 1'b1; address = 5'd4; data = 8'd7;
    tick();
    wren = 1'b0;
    tick();
    settle();
    check("hex_7_blank", hex_data, 21'b1111111_1111111_1111000);
    check("hex_addr_4", hex_addr, 14'b1111111_0011001);

    // Address hop for 5 cycles then hold: one or two updates only.
    d0 = done_cnt;
    for (int n = 0; n < 5; n++) begin
      address = AW'($urandom_range(10, 31));
      tick();
    end
    settle();
    check("hop_done_count_ok", (done_cnt - d0 >= 1) && (done_cnt - d0 <= 2), 1'b1);

    // Reset four edges into a conversion of 200.
    wren = 1'b1; address = 5'd8; data = 8'd200;
    tick();
    wren = 1'b0;
    repeat (4) tick();
    check("conv_busy", busy, 1);
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hex_data", hex_data, 21'b1111111_1111111_1000000);
    check("abort_hex_addr", hex_addr, 14'b1111111_1000000);
    tick();
    check("abort_no_done", done_cnt, d0);
    reset = 1'b0;
    settle();

    // Random traffic; the monitor checks every update on the way.
    for (int n = 0; n < 14; n++) begin
      wren    = ($urandom_range(0, 3) == 0);
      address = AW'($urandom_range(0, 31));
      data    = DW'($urandom_range(0, 255));
      hold    = $urandom_range(1, 14);
      repeat (hold) tick();
    end
    settle();

    // Wide instance, no blanking: 7 shows as 0007, 1023 after 12 edges.
    w_wren = 1'b1; w_address = 5'd3; w_data = 10'd7;
    tick();
    check("w_write_through", w_out, 7);
    w_wren = 1'b0;
    repeat (40) tick();
    check("w_hex_7_zeros", w_hex_data, 28'b1000000_1000000_1000000_1111000);
    check("w_hex_addr_3", w_hex_addr, 14'b1000000_0110000);
    w_wren = 1'b1; w_address = 5'd5; w_data = 10'd1023;
    tick();
    check("w_write_1023", w_out, 1023);
    w_wren = 1'b0;
    edges = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (w_done) begin edges = n; break; end
    end
    check("w_latency_edges", edges, 12);
    check("w_hex_1023", w_hex_data, 28'b1111001_1000000_0100100_0110000);
    check("w_hex_addr_5", w_hex_addr, 14'b1000000_0010010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memoria_bcd.md
# memoria_bcd

Parametrised single-port RAM with a registered read port and sequential binary-to-BCD readout of both the word at the current address and the address itself. Drives active-low seven-segment digit buses for board-level inspection. Replaces the fixed 8-bit/combinational-divide display path with a shift-add-3 (double-dabble) engine, adding change detection, a busy/done handshake and leading-zero blanking.

## Interface
- DATA_W, 8: word width; 2 ≤ DATA_W ≤ 16.
- ADDR_W, 5: address width; depth = 2^ADDR_W; ADDR_W ≤ DATA_W.
- DIGITS, 3: data display digits; 10^DIGITS > 2^DATA_W − 1.
- ADDR_DIGITS, 2: address display digits; 10^ADDR_DIGITS > 2^ADDR_W − 1.
- BLANK_LZ, 1: 1 blanks leading zero digits; the units digit is never blanked.

- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- address  in  ADDR_W  read/write address.
- data  in  DATA_W  write data.
- wren  in  1  write enable.
- out  out  DATA_W  registered read data.
- hex_data  out  7*DIGITS  data digits; units in [6:0], active-low gfedcba.
- hex_addr  out  7*ADDR_DIGITS  address digits, same format.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when the hex buses update.
- led_wren  out  1  registered copy of wren.

## Operation
- Write: wren=1 at an edge → mem[address]=data; out=data on that edge (write-through).
- Read: wren=0 → out=mem[address] on the edge. RAM contents are not reset.
- FSM IDLE → CONV → DONE → IDLE.
- IDLE: if out ≠ last_val or address register ≠ last_addr, latch both into last_val/last_addr and shift registers, clear BCD accumulators, set busy → CONV.
- CONV: exactly DATA_W steps. Each step adds 3 to every BCD nibble ≥ 5, then shifts {bcd, bin} left by 1, MSB first. Address is zero-extended to DATA_W and converted in parallel.
- DONE: commit BCD to digit registers, done=1, busy=0 → IDLE.
- Inputs changing during CONV/DONE are ignored. IDLE re-compares on the next cycle, so the last value is always eventually displayed.
- Segment encoding: 0–9 standard (0 = 1000000, 1 = 1111001 … 9 = 0010000). Blank and any nibble > 9 = 1111111.
- BLANK_LZ: a digit is blanked if it and every more-significant digit are zero.

## Timing
- Reset values: out=0, digit registers=0, last_val=0, last_addr=0, busy=0, done=0, led_wren=0, state IDLE.
- After reset, with BLANK_LZ=1: hex_data units = 1000000 and all other digits blank; hex_addr likewise.
- No conversion starts after reset until out or address differs from 0.
- Latency: address/data sampled at edge E0 → busy high after E1 → hex buses and done valid after E(DATA_W+2). For DATA_W=8 this is 10 edges.
- Hex buses hold their old value throughout a conversion; no intermediate digits are ever visible.
- Reset asserted mid-conversion: abort at that edge, all outputs to reset values.
- Back-to-back changes: at most one conversion in flight. Minimum update period is DATA_W+2 cycles.

## Structure
- Package memoria_bcd_pkg holds:
  - FSM state encoding (IDLE, CONV, DONE).
  - Seven-segment constants SEG_0..SEG_9 and SEG_BLANK.
  - add3 nibble function and seg7 encode function.
  - Elaboration checks for the DIGITS/ADDR_DIGITS sufficiency rules.
- Sub-module conversor_bcd (params IN_W, N_DIGITS; ports clock, reset, start, bin, busy, done, bcd) is instantiated twice, for data and address, sharing one start. The top owns the RAM, change detection and segment encoding.

## Test plan
- Reset → out=0, busy=0, done=0, hex_data[6:0]=1000000, hex_data[20:7] all 1s; no done within 20 cycles.
- Write 8'd255 at addr 31 (wren=1, one edge) → out=255 same edge; done after 10 edges; hex_data = 2,5,5 (0100100, 0010010, 0010010); hex_addr = 3,1.
- Write 7 at addr 4, then read addr 4 → hex_data units=1111000, tens/hundreds blank. With BLANK_LZ=0 they show 1000000.
- Change address every cycle for 5 cycles, then hold → exactly one or two done pulses. Final hex shows the held address and its contents; hex never shows an intermediate value mid-conversion.
- Assert reset 4 cycles into a conversion of 200 → next edge busy=0, digits at reset values, no done pulse.
- DATA_W=10, DIGITS=4: write 1023 → hex_data = 1,0,2,3 after 12 edges.
